// File: rtl/stopwatch_timekeeper_pkg.sv
// stopwatch_pkg: shared types, constants and BCD helper
// for the stopwatch timekeeper slice.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    RUN    = 2'd1,
    ADJUST = 2'd2
  } sw_state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_MAX_TENS = 4'd5;
  localparam bcd_t BCD_MAX      = 4'd9;
  localparam int   DEF_MAX_MIN  = 59;

  typedef struct packed {
    logic wrap;
    bcd_t tens;
    bcd_t ones;
  } bcd_pair_t;

  // Two-digit BCD +1; rolls to 00 and flags wrap past max.
  function automatic bcd_pair_t bcd_inc(
    input bcd_t tens,
    input bcd_t ones,
    input bcd_t max_tens,
    input bcd_t max_ones
  );
    bcd_pair_t r;
    r.wrap = 1'b0;
    r.tens = tens;
    r.ones = ones;
    if (tens == max_tens && ones == max_ones) begin
      r.wrap = 1'b1;
      r.tens = '0;
      r.ones = '0;
    end else if (ones == BCD_MAX) begin
      r.ones = '0;
      r.tens = tens + 4'd1;
    end else begin
      r.ones = ones + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_timekeeper_if.sv
// stopwatch_timekeeper_if: control inputs and display
// outputs of the timekeeper, master = driver side.
interface stopwatch_timekeeper_if;
  import stopwatch_pkg::*;

  logic CLK_1HZ;
  logic CLK_2HZ;
  logic BTN_PAUSE;
  logic ADJ;
  logic SEL;
  bcd_t MIN_TENS;
  bcd_t MIN_ONES;
  bcd_t SEC_TENS;
  bcd_t SEC_ONES;
  logic RUNNING;
  logic ADJ_ACTIVE;
  logic ADJ_FIELD;

  modport master (
    output CLK_1HZ, CLK_2HZ, BTN_PAUSE, ADJ, SEL,
    input  MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES,
    input  RUNNING, ADJ_ACTIVE, ADJ_FIELD
  );

  modport slave (
    input  CLK_1HZ, CLK_2HZ, BTN_PAUSE, ADJ, SEL,
    output MIN_TENS, MIN_ONES, SEC_TENS, SEC_ONES,
    output RUNNING, ADJ_ACTIVE, ADJ_FIELD
  );

endinterface

// File: rtl/stopwatch_timekeeper_clk_edge_sync.sv
// clk_edge_sync: STAGES-deep synchronizer (STAGES >= 2),
// history flop and registered one-cycle rise enable.
module clk_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic en
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] fill_q;
  logic              hist_q;
  logic              armed_q;
  logic              en_q;
  logic              sync_out;

  assign sync_out = sync_q[STAGES-1];

  // Zeros shifted in by reset are not real samples, so the
  // edge detector arms only once a genuine low has arrived.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      fill_q  <= '0;
      hist_q  <= 1'b0;
      armed_q <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], din};
      fill_q  <= {fill_q[STAGES-2:0], 1'b1};
      hist_q  <= sync_out;
      armed_q <= armed_q
               | (fill_q[STAGES-1] & ~sync_out);
      en_q    <= armed_q & sync_out & ~hist_q;
    end
  end

  assign en = en_q;

endmodule

// File: rtl/stopwatch_timekeeper.sv
// stopwatch_timekeeper: MM:SS BCD stopwatch with run/pause/adjust.
// Define STOPWATCH_WRAP_EN to roll MAX_MIN:59 over to 00:00.
module stopwatch_timekeeper
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = DEF_MAX_MIN
) (
  input logic             CLK_REF,
  input logic             RST,
  stopwatch_timekeeper_if.slave bus
);

  localparam bcd_t MAX_MIN_T = bcd_t'(MAX_MIN / 10);
  localparam bcd_t MAX_MIN_O = bcd_t'(MAX_MIN % 10);

  logic      en_1hz;
  logic      en_2hz;
  sw_state_e state_q;
  sw_state_e state_d;
  bcd_t      min_t_q, min_o_q, sec_t_q, sec_o_q;
  bcd_t      min_t_d, min_o_d, sec_t_d, sec_o_d;
  bcd_pair_t sec_inc;
  bcd_pair_t min_inc;
  logic      at_max;
  logic      running_q;
  logic      adj_active_q;
  logic      adj_field_q;

  clk_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync_1hz (
    .clk (CLK_REF),
    .rst (RST),
    .din (bus.CLK_1HZ),
    .en  (en_1hz)
  );

  clk_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync_2hz (
    .clk (CLK_REF),
    .rst (RST),
    .din (bus.CLK_2HZ),
    .en  (en_2hz)
  );

  assign sec_inc = bcd_inc(sec_t_q, sec_o_q,
                           SEC_MAX_TENS, BCD_MAX);
  assign min_inc = bcd_inc(min_t_q, min_o_q,
                           MAX_MIN_T, MAX_MIN_O);
  assign at_max  = sec_inc.wrap & min_inc.wrap;

  // Next state and next time digits.
  always_comb begin
    state_d = state_q;
    min_t_d = min_t_q;
    min_o_d = min_o_q;
    sec_t_d = sec_t_q;
    sec_o_d = sec_o_q;
    unique case (state_q)
      PAUSED: begin
        if (bus.ADJ) begin
          state_d = ADJUST;
        end else if (bus.BTN_PAUSE) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (en_1hz) begin
          if (at_max) begin
`ifdef STOPWATCH_WRAP_EN
            min_t_d = '0;
            min_o_d = '0;
            sec_t_d = '0;
            sec_o_d = '0;
`else
            state_d = PAUSED;
`endif
          end else begin
            sec_t_d = sec_inc.tens;
            sec_o_d = sec_inc.ones;
            if (sec_inc.wrap) begin
              min_t_d = min_inc.tens;
              min_o_d = min_inc.ones;
            end
          end
        end
        if (bus.ADJ) begin
          state_d = ADJUST;
        end else if (bus.BTN_PAUSE) begin
          state_d = PAUSED;
        end
      end
      ADJUST: begin
        if (en_2hz) begin
          if (bus.SEL) begin
            sec_t_d = sec_inc.tens;
            sec_o_d = sec_inc.ones;
          end else begin
            min_t_d = min_inc.tens;
            min_o_d = min_inc.ones;
          end
        end
        if (!bus.ADJ) begin
          state_d = PAUSED;
        end
      end
      default: begin
        state_d = PAUSED;
      end
    endcase
  end

  // State register.
  always_ff @(posedge CLK_REF) begin
    if (RST) begin
      state_q <= PAUSED;
    end else begin
      state_q <= state_d;
    end
  end

  // Time digits and registered status outputs.
  always_ff @(posedge CLK_REF) begin
    if (RST) begin
      min_t_q      <= '0;
      min_o_q      <= '0;
      sec_t_q      <= '0;
      sec_o_q      <= '0;
      running_q    <= 1'b0;
      adj_active_q <= 1'b0;
      adj_field_q  <= 1'b0;
    end else begin
      min_t_q      <= min_t_d;
      min_o_q      <= min_o_d;
      sec_t_q      <= sec_t_d;
      sec_o_q      <= sec_o_d;
      running_q    <= (state_d == RUN);
      adj_active_q <= (state_d == ADJUST);
      adj_field_q  <= (state_d == ADJUST) & bus.SEL;
    end
  end

  assign bus.MIN_TENS   = min_t_q;
  assign bus.MIN_ONES   = min_o_q;
  assign bus.SEC_TENS   = sec_t_q;
  assign bus.SEC_ONES   = sec_o_q;
  assign bus.RUNNING    = running_q;
  assign bus.ADJ_ACTIVE = adj_active_q;
  assign bus.ADJ_FIELD  = adj_field_q;

endmodule

// File: tb/tb_stopwatch_timekeeper.sv
// tb_stopwatch_timekeeper: vector table plus digit-change
// scoreboard with arrival-cycle checks.
module tb_stopwatch_timekeeper;

  localparam int MAXM = 59;

  logic CLK_REF = 1'b0;
  logic RST;
  always #5 CLK_REF = ~CLK_REF;

  stopwatch_timekeeper_if bus();

  stopwatch_timekeeper #(
    .SYNC_STAGES (2),
    .MAX_MIN     (MAXM)
  ) dut (
    .CLK_REF (CLK_REF),
    .RST     (RST),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] dig;
    int          at;
  } exp_t;

  typedef struct {
    bit          adj;
    bit          sel;
    bit          btn;
    int          n1;
    int          n2;
    logic [15:0] dig;
    bit          run;
    bit          aa;
    bit          af;
  } vec_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sbq[$];
  exp_t mon_e;
  int   mm = 0;
  int   ss = 0;
  int   st = 0;
  bit   mon_en = 1'b0;
  logic [15:0] prev;
  logic [15:0] digits;

  assign digits = {bus.MIN_TENS, bus.MIN_ONES,
                   bus.SEC_TENS, bus.SEC_ONES};

  always @(posedge CLK_REF) cyc <= cyc + 1;

  function automatic logic [15:0] pack(int m, int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic vec_t mk(bit a, bit s, bit b, int n1,
                              int n2, logic [15:0] d,
                              bit r, bit aa, bit af);
    vec_t v;
    v.adj = a; v.sel = s; v.btn = b;
    v.n1 = n1; v.n2 = n2; v.dig = d;
    v.run = r; v.aa = aa; v.af = af;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge CLK_REF);
      #1;
    end
  endtask

  task automatic push(int lat);
    exp_t e;
    e.dig = pack(mm, ss);
    e.at  = cyc + lat;
    sbq.push_back(e);
  endtask

  // Every digit change must match the oldest expectation,
  // on the expected cycle.
  always @(posedge CLK_REF) begin
    #1;
    if (mon_en && digits !== prev) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected", digits, prev);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_digits", digits, mon_e.dig);
        chk("sb_cycle", cyc, mon_e.at);
      end
    end
    prev = digits;
  end

  task automatic do_reset();
    RST = 1'b1;
    if (pack(mm, ss) != 16'h0000) begin
      mm = 0; ss = 0;
      push(1);
    end
    st = 0;
    tick(2);
    RST = 1'b0;
    tick(5);
  endtask

  task automatic btn();
    bus.BTN_PAUSE = 1'b1;
    if (st == 0) st = 1;
    else if (st == 1) st = 0;
    tick();
    bus.BTN_PAUSE = 1'b0;
    tick();
  endtask

  task automatic set_adj(bit a, bit s);
    bus.ADJ = a;
    bus.SEL = s;
    if (a) st = 2;
    else if (st == 2) st = 0;
    tick(2);
  endtask

  task automatic one_sec(int hi = 4);
    bus.CLK_1HZ = 1'b1;
    if (st == 1) begin
      if (mm == MAXM && ss == 59) begin
`ifdef STOPWATCH_WRAP_EN
        mm = 0; ss = 0;
        push(4);
`else
        st = 0;
`endif
      end else begin
        ss++;
        if (ss == 60) begin
          ss = 0;
          mm++;
        end
        push(4);
      end
    end
    tick(hi);
    bus.CLK_1HZ = 1'b0;
    tick(4);
  endtask

  task automatic one_2hz();
    bus.CLK_2HZ = 1'b1;
    if (st == 2) begin
      if (bus.SEL) ss = (ss + 1) % 60;
      else mm = (mm + 1) % (MAXM + 1);
      push(4);
    end
    tick(4);
    bus.CLK_2HZ = 1'b0;
    tick(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[11];
    logic [15:0] term_d;
    bit          term_r;
    bit          ok;

    tbl[0]  = mk(1, 1, 0, 0, 58, 16'h0058, 0, 1, 1);
    tbl[1]  = mk(1, 1, 0, 0,  3, 16'h0001, 0, 1, 1);
    tbl[2]  = mk(1, 0, 0, 0,  2, 16'h0201, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 2,  0, 16'h0201, 0, 0, 0);
    tbl[4]  = mk(1, 1, 0, 2,  0, 16'h0201, 0, 1, 1);
    tbl[5]  = mk(1, 1, 0, 0, 58, 16'h0259, 0, 1, 1);
    tbl[6]  = mk(1, 0, 0, 0, 58, 16'h0059, 0, 1, 0);
    tbl[7]  = mk(0, 0, 1, 1,  0, 16'h0100, 1, 0, 0);
    tbl[8]  = mk(1, 0, 0, 0, 58, 16'h5900, 0, 1, 0);
    tbl[9]  = mk(1, 1, 0, 0, 59, 16'h5959, 0, 1, 1);
    tbl[10] = mk(0, 0, 1, 0,  0, 16'h5959, 1, 0, 0);

    bus.CLK_1HZ   = 1'b0;
    bus.CLK_2HZ   = 1'b0;
    bus.BTN_PAUSE = 1'b0;
    bus.ADJ       = 1'b0;
    bus.SEL       = 1'b0;
    RST           = 1'b1;
    tick(3);
    RST = 1'b0;
    tick(5);
    mon_en = 1'b1;

    chk("rst_digits", digits, 16'h0000);
    chk("rst_running", bus.RUNNING, 0);
    chk("rst_adj_active", bus.ADJ_ACTIVE, 0);
    chk("rst_adj_field", bus.ADJ_FIELD, 0);

    btn();
    chk("start_running", bus.RUNNING, 1);
    repeat (75) one_sec();
    chk("count75_digits", digits, 16'h0115);
    chk("count75_running", bus.RUNNING, 1);

    do_reset();
    btn();
    repeat (10) one_sec();
    chk("at10_digits", digits, 16'h0010);
    bus.CLK_1HZ = 1'b1;
    ss = 11;
    push(4);
    tick(3);
    bus.BTN_PAUSE = 1'b1;
    st = 0;
    tick();
    bus.BTN_PAUSE = 1'b0;
    chk("pause_same_running", bus.RUNNING, 0);
    tick(3);
    bus.CLK_1HZ = 1'b0;
    tick(4);
    repeat (2) one_sec();
    chk("pause_same_digits", digits, 16'h0011);
    chk("pause_same_still", bus.RUNNING, 0);

    do_reset();
    for (int i = 0; i < 11; i++) begin
      set_adj(tbl[i].adj, tbl[i].sel);
      if (tbl[i].btn) btn();
      repeat (tbl[i].n1) one_sec();
      repeat (tbl[i].n2) one_2hz();
      chk($sformatf("vec%0d_digits", i), digits, tbl[i].dig);
      chk($sformatf("vec%0d_running", i),
          bus.RUNNING, tbl[i].run);
      chk($sformatf("vec%0d_adj_active", i),
          bus.ADJ_ACTIVE, tbl[i].aa);
      chk($sformatf("vec%0d_adj_field", i),
          bus.ADJ_FIELD, tbl[i].af);
    end

`ifdef STOPWATCH_WRAP_EN
    term_d = 16'h0000;
    term_r = 1'b1;
`else
    term_d = 16'h5959;
    term_r = 1'b0;
`endif
    one_sec();
    chk("term_digits", digits, term_d);
    chk("term_running", bus.RUNNING, term_r);
    btn();
    one_sec();
    chk("term2_digits", digits, pack(mm, ss));
    chk("term2_running", bus.RUNNING, st == 1);

    do_reset();
    set_adj(1, 0);
    repeat (12) one_2hz();
    set_adj(1, 1);
    repeat (34) one_2hz();
    set_adj(0, 0);
    btn();
    chk("preload_digits", digits, 16'h1234);
    bus.CLK_1HZ = 1'b1;
    ss = 35;
    push(4);
    tick(4);
    do_reset();
    tick(1);
    chk("midrst_digits", digits, 16'h0000);
    chk("midrst_running", bus.RUNNING, 0);
    btn();
    tick(8);
    chk("midrst_hold_digits", digits, 16'h0000);
    bus.CLK_1HZ = 1'b0;
    tick(4);
    one_sec();
    chk("midrst_count", digits, 16'h0001);
    chk("midrst_run", bus.RUNNING, 1);

    one_sec(3);
    chk("pulse3_digits", digits, 16'h0002);
    chk("sb_drained", sbq.size(), 0);

    mon_en = 1'b0;
    bus.CLK_1HZ = 1'b1;
    tick(1);
    bus.CLK_1HZ = 1'b0;
    tick(8);
    ok = (digits == 16'h0002) || (digits == 16'h0003);
    chk("pulse1_at_most_one", ok, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
